// File: rtl/dtc_vote_pkg.sv
// ---------------------------------------------------------------------------
// dtc_vote_pkg
// Shared types and default constants for the decision-tree vote accumulator.
//   vote_state_t : accumulator FSM states (ACCUM, SCAN, HOLD)
//   DTC_N_CLASSES: default number of classes / vote counters
//   DTC_WINDOW   : default samples per decision window
//   class_idx_t  : class index type sized for the default class count
// ---------------------------------------------------------------------------
package dtc_vote_pkg;

   localparam int DTC_N_CLASSES = 18;
   localparam int DTC_WINDOW    = 16;

   typedef enum logic [1:0] {
      ACCUM = 2'd0,
      SCAN  = 2'd1,
      HOLD  = 2'd2
   } vote_state_t;

   typedef logic [$clog2(DTC_N_CLASSES)-1:0] class_idx_t;

endpackage

// File: rtl/dtc_vote_counter.sv
// ---------------------------------------------------------------------------
// dtc_vote_counter
// One per-class vote counter. Synchronous clear has priority over increment.
// Ports:
//   clk   in   clock
//   rst_n in   asynchronous active-low reset
//   clr   in   synchronous clear
//   inc   in   add one vote
//   cnt   out  current vote count (CNT_W bits)
// ---------------------------------------------------------------------------
module dtc_vote_counter #(
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/dtc_vote_accumulator.sv
// ---------------------------------------------------------------------------
// dtc_vote_accumulator
// Accumulates per-class votes from a decision-tree classifier over a window
// of samples, then scans the counters one class per cycle and presents the
// winning class (lowest index on ties) on a valid/ready output.
// Build option: define DTC_VOTE_TIE_EN to add the out_tie output, which flags
// that another class shares the non-zero winning count.
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   class vector valid
//   in_ready  out  accumulator accepts a vector (state is ACCUM)
//   in_vec    in   multi-hot class vector, bit i = vote for class i
//   flush     in   close a non-empty window early
//   out_valid out  decision valid
//   out_ready in   downstream accepts the decision
//   out_class out  winning class index
//   out_count out  votes of the winning class
//   out_none  out  window held no votes
//   out_tie   out  (DTC_VOTE_TIE_EN only) another class ties the winner
// ---------------------------------------------------------------------------
// state | meaning
// ACCUM | accepting vectors, counting votes and samples
// SCAN  | visiting one class counter per cycle, tracking max/argmax
// HOLD  | decision registered, waiting for out_ready
// ---------------------------------------------------------------------------
module dtc_vote_accumulator
   import dtc_vote_pkg::*;
#(
   parameter int N_CLASSES = DTC_N_CLASSES,
   parameter int WINDOW    = DTC_WINDOW,
   parameter int CNT_W     = $clog2(WINDOW + 1),
   parameter int IDX_W     = $clog2(N_CLASSES)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N_CLASSES-1:0] in_vec,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [IDX_W-1:0]     out_class,
   output logic [CNT_W-1:0]     out_count,
`ifdef DTC_VOTE_TIE_EN
   output logic                 out_none,
   output logic                 out_tie
`else
   output logic                 out_none
`endif
);

   vote_state_t      state;
   logic [CNT_W-1:0] samp_cnt;
   logic [IDX_W-1:0] scan_idx;
   logic [CNT_W-1:0] max_cnt;
   logic [IDX_W-1:0] max_idx;

   logic [CNT_W-1:0] vote_cnt [N_CLASSES];
   logic             transfer;
   logic             win_close;
   logic             cnt_clr;
   logic [CNT_W-1:0] cur_cnt;
   logic             scan_gt;
   logic [CNT_W-1:0] nxt_max;
   logic [IDX_W-1:0] nxt_idx;
   logic             scan_last;

   assign in_ready  = (state == ACCUM);
   assign transfer  = in_valid && in_ready;
   assign cnt_clr   = (state == HOLD) && out_ready;
   assign scan_last = (scan_idx == IDX_W'(N_CLASSES - 1));

   // Window closes when this transfer fills it, or on flush when the window
   // holds (or is about to hold) at least one sample.
   assign win_close = (transfer && (samp_cnt == CNT_W'(WINDOW - 1))) ||
                      (flush && in_ready && (transfer || (samp_cnt != '0)));

   for (genvar g = 0; g < N_CLASSES; g++) begin : g_cnt
      dtc_vote_counter #(.CNT_W(CNT_W)) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (cnt_clr),
         .inc   (transfer && in_vec[g]),
         .cnt   (vote_cnt[g])
      );
   end

   // Counter selected by the scan index; explicit compare avoids indexing
   // past N_CLASSES when it is not a power of two.
   always_comb begin
      cur_cnt = '0;
      for (int i = 0; i < N_CLASSES; i++) begin
         if (scan_idx == IDX_W'(i)) cur_cnt = vote_cnt[i];
      end
   end

   // Strictly-greater update keeps the lowest index on ties.
   assign scan_gt = (cur_cnt > max_cnt);
   assign nxt_max = scan_gt ? cur_cnt  : max_cnt;
   assign nxt_idx = scan_gt ? scan_idx : max_idx;

`ifdef DTC_VOTE_TIE_EN
   logic tie_run;
   logic nxt_tie;

   // A new strict max cancels any earlier tie; equal non-zero counts set it.
   assign nxt_tie = scan_gt ? 1'b0
                            : (tie_run || ((cur_cnt == max_cnt) && (cur_cnt != '0)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tie_run <= 1'b0;
         out_tie <= 1'b0;
      end else begin
         if (state == ACCUM && win_close) begin
            tie_run <= 1'b0;
         end else if (state == SCAN) begin
            tie_run <= nxt_tie;
            if (scan_last) out_tie <= nxt_tie;
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ACCUM;
         samp_cnt  <= '0;
         scan_idx  <= '0;
         max_cnt   <= '0;
         max_idx   <= '0;
         out_valid <= 1'b0;
         out_class <= '0;
         out_count <= '0;
         out_none  <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (transfer) samp_cnt <= samp_cnt + CNT_W'(1);
               if (win_close) begin
                  state    <= SCAN;
                  scan_idx <= '0;
                  max_cnt  <= '0;
                  max_idx  <= '0;
               end
            end
            SCAN: begin
               max_cnt  <= nxt_max;
               max_idx  <= nxt_idx;
               scan_idx <= scan_idx + IDX_W'(1);
               if (scan_last) begin
                  out_valid <= 1'b1;
                  out_class <= nxt_idx;
                  out_count <= nxt_max;
                  out_none  <= (nxt_max == '0);
                  state     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  samp_cnt  <= '0;
                  state     <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_dtc_vote_accumulator.sv
module tb_dtc_vote_accumulator;
   import dtc_vote_pkg::*;

   localparam int N     = DTC_N_CLASSES;
   localparam int WIN   = DTC_WINDOW;
   localparam int CNT_W = $clog2(WIN + 1);
   localparam int IDX_W = $clog2(N);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [N-1:0]     in_vec = '0;
   logic             flush = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [IDX_W-1:0] out_class;
   logic [CNT_W-1:0] out_count;
   logic             out_none;
`ifdef DTC_VOTE_TIE_EN
   logic             out_tie;
`endif

   int tests = 0;
   int fails = 0;

   dtc_vote_accumulator dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_class (out_class),
      .out_count (out_count),
`ifdef DTC_VOTE_TIE_EN
      .out_none  (out_none),
      .out_tie   (out_tie)
`else
      .out_none  (out_none)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [N-1:0] vec_a;
      int           n_a;
      logic [N-1:0] vec_b;
      int           n_b;
      bit           do_flush;
      int           exp_class;
      int           exp_count;
      bit           exp_none;
      bit           exp_tie;
   } win_rec_t;

   win_rec_t tbl [4];

   // Waits for out_valid; lat counts clock edges after the closing edge.
   // Closing edge ends cycle t, decision visible in cycle t+1+N -> lat == N.
   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 60) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic handshake();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check("hs_out_valid", int'(out_valid), 0);
      check("hs_in_ready", int'(in_ready), 1);
   endtask

   task automatic feed(input logic [N-1:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_vec   = v;
         @(posedge clk);
      end
   endtask

   task automatic do_flush();
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b1;
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_vec   = '0;
      flush    = 1'b0;
   endtask

   task automatic run_window(input win_rec_t r, input string tag);
      int lat;
      feed(r.vec_a, r.n_a);
      feed(r.vec_b, r.n_b);
      if (r.do_flush) do_flush();
      idle();
      wait_valid(lat);
      check({tag, "_latency"}, lat, N);
      check({tag, "_class"}, int'(out_class), r.exp_class);
      check({tag, "_count"}, int'(out_count), r.exp_count);
      check({tag, "_none"}, int'(out_none), int'(r.exp_none));
`ifdef DTC_VOTE_TIE_EN
      check({tag, "_tie"}, int'(out_tie), int'(r.exp_tie));
`endif
      check({tag, "_in_ready"}, int'(in_ready), 0);
      handshake();
   endtask

   // ---------------- reference model for random phase ----------------
   int   votes [N];
   int   nsamp;
   bit   closed;
   int   close_cyc;
   int   cyc;
   int   m_class, m_count;
   bit   m_none, m_tie;

   task automatic model_clear();
      for (int i = 0; i < N; i++) votes[i] = 0;
      nsamp  = 0;
      closed = 1'b0;
   endtask

   task automatic model_decide();
      int ties;
      m_class = 0;
      m_count = 0;
      for (int i = 0; i < N; i++) begin
         if (votes[i] > m_count) begin
            m_count = votes[i];
            m_class = i;
         end
      end
      ties = 0;
      for (int i = 0; i < N; i++) if (votes[i] == m_count) ties++;
      m_none = (m_count == 0);
      m_tie  = (m_count > 0) && (ties > 1);
   endtask

   initial begin
      int        lat;
      bit        seen;
      bit        exp_valid;
      class_idx_t hold_class;
      int        hold_count;

      tbl[0] = '{18'h00020, 16, 18'h0,     0, 1'b0,  5, 16, 1'b0, 1'b0};
      tbl[1] = '{18'h20000, 10, 18'h00008, 6, 1'b0, 17, 10, 1'b0, 1'b0};
      tbl[2] = '{18'h00004,  8, 18'h00200, 8, 1'b0,  2,  8, 1'b0, 1'b1};
      tbl[3] = '{18'h0,      3, 18'h0,     0, 1'b1,  0,  0, 1'b1, 1'b0};

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_class", int'(out_class), 0);
      check("rst_out_count", int'(out_count), 0);
      check("rst_out_none", int'(out_none), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", int'(in_ready), 1);

      // Table-driven windows
      for (int k = 0; k < 4; k++) run_window(tbl[k], $sformatf("tbl%0d", k));

      // Flush on an empty window produces nothing
      do_flush();
      idle();
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid || !in_ready) seen = 1'b1;
      end
      check("empty_flush_ignored", int'(seen), 0);

      // Transfer plus flush in the same cycle: sample included
      @(negedge clk);
      in_valid = 1'b1; in_vec = 18'h00100; flush = 1'b1;
      @(posedge clk);
      idle();
      wait_valid(lat);
      check("xfer_flush_latency", lat, N);
      check("xfer_flush_class", int'(out_class), 8);
      check("xfer_flush_count", int'(out_count), 1);

      // Stall in HOLD: outputs stable, in_ready low
      hold_class = class_idx_t'(out_class);
      hold_count = int'(out_count);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!out_valid || in_ready || out_class != hold_class ||
             int'(out_count) != hold_count) seen = 1'b1;
      end
      check("hold_stable", int'(seen), 0);
      handshake();

      // Counters cleared after handshake: single vote window
      run_window('{18'h00002, 1, 18'h0, 0, 1'b1, 1, 1, 1'b0, 1'b0}, "post_clear");

      // Reset mid-HOLD
      feed(18'h00080, WIN);
      idle();
      wait_valid(lat);
      check("pre_rst_valid", int'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      check("rst_hold_out_valid", int'(out_valid), 0);
      check("rst_hold_out_class", int'(out_class), 0);
      check("rst_hold_out_count", int'(out_count), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_hold_in_ready", int'(in_ready), 1);

      // Reset mid-SCAN: no decision, partial window discarded
      feed(18'h00400, WIN);
      idle();
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("rst_scan_no_output", int'(seen), 0);
      run_window('{18'h00010, 2, 18'h0, 0, 1'b1, 4, 2, 1'b0, 1'b0}, "post_rst_scan");

      // Random phase against the reference model
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
      cyc = 0; close_cyc = 0;
      m_class = 0; m_count = 0; m_none = 1'b0; m_tie = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         exp_valid = closed && (cyc >= close_cyc + N);
         check("rnd_in_ready", int'(in_ready), int'(!closed));
         check("rnd_out_valid", int'(out_valid), int'(exp_valid));
         if (exp_valid && out_valid) begin
            check("rnd_class", int'(out_class), m_class);
            check("rnd_count", int'(out_count), m_count);
            check("rnd_none", int'(out_none), int'(m_none));
`ifdef DTC_VOTE_TIE_EN
            check("rnd_tie", int'(out_tie), int'(m_tie));
`endif
         end
         in_valid  = ($urandom_range(0, 1) == 1);
         in_vec    = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom & $urandom);
         flush     = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 2) == 0);
         @(posedge clk);
         cyc++;
         if (!closed) begin
            if (in_valid) begin
               for (int i = 0; i < N; i++) votes[i] += int'(in_vec[i]);
               nsamp++;
            end
            if (nsamp == WIN || (flush && nsamp > 0)) begin
               closed    = 1'b1;
               close_cyc = cyc;
               model_decide();
            end
         end else if (exp_valid && out_ready) begin
            model_clear();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
